output_port_fifo: RTL and testbench
===================================

# output_port_fifo

Per-output-port flit buffer of the NoC router, sitting between the crossbar and the outgoing link to the neighbouring router. It stores flits written by the crossbar and drains them downstream under a valid/ready handshake. It produces the per-port ready signal that the router's flow-control logic consumes (the N/E/W/S/L ready_in inputs), which gates further switching into this port. It also reports packet completion so the arbiter can release the port grant.

## Interface
Parameters:
- DATA_WIDTH, 32, flit payload width
- DEPTH, 4, buffer entries; power of two, >= 2
- READY_MARGIN, 1, free-slot slack kept when dropping ready_out; legal 0..DEPTH-1

Ports:
- clk  in  1  router clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  DATA_WIDTH  flit from crossbar
- tail_in  in  1  marks data_in as the packet's tail flit
- wr_en  in  1  crossbar write strobe
- ready_out  out  1  space available; feeds flow control as this port's ready_in
- data_out  out  DATA_WIDTH  flit toward downstream router
- tail_out  out  1  tail flag of the flit on data_out
- valid_out  out  1  data_out holds a flit
- ready_dn  in  1  downstream router accepts a flit
- pkt_sent  out  1  one-cycle pulse: tail flit handed downstream
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a write arrived while full

## Operation
- Circular buffer: wr_ptr, rd_ptr (log2(DEPTH) bits, natural wrap), registered count. Each entry stores {tail, data}.
- Write: at a posedge with wr_en=1 and count<DEPTH, store the entry at wr_ptr and increment wr_ptr.
- Write while full: at a posedge with wr_en=1 and count==DEPTH, the write is dropped and overflow is set to 1. This applies even when a read occurs in the same cycle. overflow is cleared only by reset.
- Read/handoff: valid_out = (count!=0); data_out/tail_out = entry at rd_ptr (first-word fall-through). A handshake is valid_out & ready_dn at a posedge, which increments rd_ptr.
- Simultaneous accepted write and handshake: count unchanged. When empty, only the write can occur.
- count_next = count + write_accepted - handshake.
- ready_out is registered: ready_out <= (count_next < DEPTH - READY_MARGIN).
- pkt_sent is registered: pkt_sent <= handshake & tail_out.
- Data stability: while valid_out=1 and ready_dn=0, data_out and tail_out must not change.
- No state machine beyond the pointers and counter. Packet boundaries come only from tail flags.

## Timing
- Reset (rst_n low, asynchronous): pointers=0, count=0, ready_out=0, pkt_sent=0, overflow=0. valid_out=0 follows immediately from count. data_out and tail_out are don't-care while valid_out=0.
- The first posedge after rst_n deasserts sets ready_out=1.
- Write-to-output latency: a flit written at edge N is presented on data_out after edge N when the buffer was empty. It can be handed off at edge N+1.
- Sustained streaming (ready_dn=1, wr_en every cycle): 1 flit/cycle, count holds at 1.
- ready_out lags occupancy by zero cycles. It reflects count after the same edge, and the upstream sees it in the cycle following the write. READY_MARGIN covers the crossbar's one-cycle-late write after ready drops.
- pkt_sent is high exactly one cycle, in the cycle after the tail handshake edge.
- Reset mid-operation discards all stored flits. No pkt_sent is generated for discarded flits.

## Test plan
- Reset: hold rst_n=0 with wr_en=1 -> all outputs 0, count=0. Release; first edge -> ready_out=1, valid_out=0.
- Fill (DEPTH=4, MARGIN=1, ready_dn=0): write 0xA0..0xA2 -> ready_out=0 after third edge, count=3. Write 0xA3 -> count=4. Write 0xA4 -> dropped, overflow=1, count=4. Drain -> exactly A0,A1,A2,A3 in order.
- Streaming: ready_dn=1, write 0x10..0x1F on consecutive cycles -> each flit appears one cycle after its write, count never exceeds 1, ready_out stays 1.
- Packet end: write 0x01, 0x02, 0x03 with tail_in on 0x03, ready_dn=1 -> exactly one pkt_sent pulse, in the cycle after 0x03's handshake.
- Backpressure: buffer holds 0x55,0x66; toggle ready_dn 0/1 each cycle -> 0x55 stable until accepted, then 0x66. count decrements only on ready_dn=1 edges. ready_out rises when count drops below 3.
- Wrap and mid-reset: perform 10 write/read pairs to wrap the pointers. Then fill count=3 and pulse rst_n low between edges -> valid_out=0 and count=0 immediately. After release, write 0x77 -> data_out=0x77, no stale data.

Source files
------------

// File: rtl/output_port_fifo.sv
// Output-port flit buffer: a circular FIFO between the crossbar and the outgoing
// link. Flits drain downstream under valid/ready. ready_out feeds the router's
// flow control, and pkt_sent tells the arbiter that a packet has left the port.
module output_port_fifo #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned READY_MARGIN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    tail_in,
    input  logic                    wr_en,
    output logic                    ready_out,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    tail_out,
    output logic                    valid_out,
    input  logic                    ready_dn,
    output logic                    pkt_sent,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned RDY_LIMIT = DEPTH - READY_MARGIN;

    typedef struct packed {
        logic                  tail;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_next;
    logic            full;
    logic            wr_accept;
    logic            wr_drop;
    logic            handshake;

    // Occupancy decode and per-cycle transfer decisions.
    always_comb begin
        full       = (count == CW'(DEPTH));
        wr_accept  = wr_en & ~full;
        wr_drop    = wr_en & full;
        handshake  = valid_out & ready_dn;
        count_next = count + CW'(wr_accept) - CW'(handshake);
    end

    // First-word fall-through view of the head entry.
    always_comb begin
        head      = mem[rd_ptr];
        valid_out = (count != '0);
        data_out  = head.data;
        tail_out  = head.tail;
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= '{tail: tail_in, data: data_in};
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (handshake) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    // Flow-control ready keeps READY_MARGIN slots free for a late crossbar write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_out <= 1'b0;
        end else begin
            ready_out <= (count_next < CW'(RDY_LIMIT));
        end
    end

    // Packet-completion pulse, one cycle after the tail flit is accepted downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_sent <= 1'b0;
        end else begin
            pkt_sent <= handshake & tail_out;
        end
    end

    // Sticky record of any write attempted while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_drop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_output_port_fifo.sv
// Directed, table-driven bench for output_port_fifo (DEPTH=4, READY_MARGIN=1).
module tb_output_port_fifo;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        tail_in;
    logic        wr_en;
    logic        ready_out;
    logic [31:0] data_out;
    logic        tail_out;
    logic        valid_out;
    logic        ready_dn;
    logic        pkt_sent;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    output_port_fifo #(
        .DATA_WIDTH  (32),
        .DEPTH       (4),
        .READY_MARGIN(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .tail_in  (tail_in),
        .wr_en    (wr_en),
        .ready_out(ready_out),
        .data_out (data_out),
        .tail_out (tail_out),
        .valid_out(valid_out),
        .ready_dn (ready_dn),
        .pkt_sent (pkt_sent),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        tail;
        logic [31:0] din;
        logic        rdy;
        logic [2:0]  ec;
        logic        ev;
        logic [31:0] ed;
        logic        et;
        logic        er;
        logic        ep;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic wr, input logic tail, input logic [31:0] din,
                                input logic rdy, input logic [2:0] ec, input logic ev,
                                input logic [31:0] ed, input logic et, input logic er,
                                input logic ep, input logic eo);
        vec_t v;
        v.wr = wr; v.tail = tail; v.din = din; v.rdy = rdy;
        v.ec = ec; v.ev = ev; v.ed = ed; v.et = et; v.er = er; v.ep = ep; v.eo = eo;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, " count"}, 32'(count), 32'(v.ec));
        chk({tag, " valid_out"}, 32'(valid_out), 32'(v.ev));
        chk({tag, " ready_out"}, 32'(ready_out), 32'(v.er));
        chk({tag, " pkt_sent"}, 32'(pkt_sent), 32'(v.ep));
        chk({tag, " overflow"}, 32'(overflow), 32'(v.eo));
        if (v.ev) begin
            chk({tag, " data_out"}, data_out, v.ed);
            chk({tag, " tail_out"}, 32'(tail_out), 32'(v.et));
        end
    endtask

    // Drive one cycle of inputs, clock it, sample 1 ns after the edge.
    task automatic step(input string tag, input vec_t v);
        wr_en    = v.wr;
        tail_in  = v.tail;
        data_in  = v.din;
        ready_dn = v.rdy;
        @(posedge clk);
        #1;
        check_outs(tag, v);
    endtask

    initial begin
        vec_t v;

        // Fill with ready_dn low, overflow on 5th write, then drain in order.
        add(1,0,32'hA0,0, 3'd1,1,32'hA0,0,1,0,0);
        add(1,0,32'hA1,0, 3'd2,1,32'hA0,0,1,0,0);
        add(1,0,32'hA2,0, 3'd3,1,32'hA0,0,0,0,0);
        add(1,0,32'hA3,0, 3'd4,1,32'hA0,0,0,0,0);
        add(1,0,32'hA4,0, 3'd4,1,32'hA0,0,0,0,1);
        add(0,0,32'h0 ,1, 3'd3,1,32'hA1,0,0,0,1);
        add(0,0,32'h0 ,1, 3'd2,1,32'hA2,0,1,0,1);
        add(0,0,32'h0 ,1, 3'd1,1,32'hA3,0,1,0,1);
        add(0,0,32'h0 ,1, 3'd0,0,32'h0 ,0,1,0,1);
        // Full with simultaneous write and handshake: write is dropped.
        add(1,0,32'hB0,0, 3'd1,1,32'hB0,0,1,0,1);
        add(1,0,32'hB1,0, 3'd2,1,32'hB0,0,1,0,1);
        add(1,0,32'hB2,0, 3'd3,1,32'hB0,0,0,0,1);
        add(1,0,32'hB3,0, 3'd4,1,32'hB0,0,0,0,1);
        add(1,0,32'hB4,1, 3'd3,1,32'hB1,0,0,0,1);
        add(0,0,32'h0 ,1, 3'd2,1,32'hB2,0,1,0,1);
        add(0,0,32'h0 ,1, 3'd1,1,32'hB3,0,1,0,1);
        add(0,0,32'h0 ,1, 3'd0,0,32'h0 ,0,1,0,1);
        // Streaming at one flit per cycle.
        for (int k = 0; k < 16; k++) begin
            add(1,0,32'h10 + 32'(k),1, 3'd1,1,32'h10 + 32'(k),0,1,0,1);
        end
        add(0,0,32'h0 ,1, 3'd0,0,32'h0 ,0,1,0,1);
        // Packet end: single pkt_sent pulse after the tail handshake.
        add(1,0,32'h01,1, 3'd1,1,32'h01,0,1,0,1);
        add(1,0,32'h02,1, 3'd1,1,32'h02,0,1,0,1);
        add(1,1,32'h03,1, 3'd1,1,32'h03,1,1,0,1);
        add(0,0,32'h0 ,1, 3'd0,0,32'h0 ,0,1,1,1);
        add(0,0,32'h0 ,1, 3'd0,0,32'h0 ,0,1,0,1);
        // Backpressure: head stable while ready_dn toggles.
        add(1,0,32'h55,0, 3'd1,1,32'h55,0,1,0,1);
        add(1,0,32'h66,0, 3'd2,1,32'h55,0,1,0,1);
        add(0,0,32'h0 ,0, 3'd2,1,32'h55,0,1,0,1);
        add(0,0,32'h0 ,1, 3'd1,1,32'h66,0,1,0,1);
        add(0,0,32'h0 ,0, 3'd1,1,32'h66,0,1,0,1);
        add(0,0,32'h0 ,1, 3'd0,0,32'h0 ,0,1,0,1);
        // ready_out drops at count 3 and rises when count falls to 2.
        add(1,0,32'h81,0, 3'd1,1,32'h81,0,1,0,1);
        add(1,0,32'h82,0, 3'd2,1,32'h81,0,1,0,1);
        add(1,0,32'h83,0, 3'd3,1,32'h81,0,0,0,1);
        add(0,0,32'h0 ,1, 3'd2,1,32'h82,0,1,0,1);
        add(0,0,32'h0 ,1, 3'd1,1,32'h83,0,1,0,1);
        add(0,0,32'h0 ,1, 3'd0,0,32'h0 ,0,1,0,1);

        // Reset held with wr_en asserted.
        rst_n    = 1'b0;
        wr_en    = 1'b1;
        tail_in  = 1'b1;
        data_in  = 32'hFF;
        ready_dn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset count", 32'(count), 32'd0);
        chk("reset valid_out", 32'(valid_out), 32'd0);
        chk("reset ready_out", 32'(ready_out), 32'd0);
        chk("reset pkt_sent", 32'(pkt_sent), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        v = '{wr:0, tail:0, din:0, rdy:0, ec:3'd0, ev:0, ed:0, et:0, er:1, ep:0, eo:0};
        step("post-reset", v);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("v%0d", i), vecs[i]);
        end

        // Ten write/read pairs to wrap both pointers.
        for (int i = 0; i < 10; i++) begin
            v = '{wr:1, tail:0, din:32'hC0 + 32'(i), rdy:0, ec:3'd1, ev:1,
                  ed:32'hC0 + 32'(i), et:0, er:1, ep:0, eo:1};
            step($sformatf("wrap%0d wr", i), v);
            v = '{wr:0, tail:0, din:0, rdy:1, ec:3'd0, ev:0, ed:0, et:0, er:1, ep:0, eo:1};
            step($sformatf("wrap%0d rd", i), v);
        end

        // Fill to 3, then reset between edges.
        for (int i = 0; i < 3; i++) begin
            v = '{wr:1, tail:1, din:32'hD0 + 32'(i), rdy:0, ec:3'(i + 1), ev:1,
                  ed:32'hD0, et:1, er:(i < 2), ep:0, eo:1};
            step($sformatf("midfill%0d", i), v);
        end
        wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst count", 32'(count), 32'd0);
        chk("midrst valid_out", 32'(valid_out), 32'd0);
        chk("midrst ready_out", 32'(ready_out), 32'd0);
        chk("midrst overflow", 32'(overflow), 32'd0);
        chk("midrst pkt_sent", 32'(pkt_sent), 32'd0);
        #2;
        rst_n = 1'b1;
        v = '{wr:1, tail:0, din:32'h77, rdy:0, ec:3'd1, ev:1, ed:32'h77, et:0, er:1, ep:0, eo:0};
        step("after-rst wr77", v);
        v = '{wr:0, tail:0, din:0, rdy:1, ec:3'd0, ev:0, ed:0, et:0, er:1, ep:0, eo:0};
        step("after-rst rd77", v);
        v = '{wr:0, tail:0, din:0, rdy:1, ec:3'd0, ev:0, ed:0, et:0, er:1, ep:0, eo:0};
        step("after-rst idle", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
